// File: rtl/bissc_rx.sv
// -----------------------------------------------------------------------------
// bissc_rx : BiSS-C master receiver
//
// Purpose
//   Clocks an absolute encoder through the gated MA line (oclk) and samples the
//   returning SLO line (enc_data) on every rising edge of enc_clk. From each
//   frame it extracts a POS_W-bit position and the nError/nWarn bits, and checks
//   the CRC6 (x^6+x+1, init 0, transmitted inverted). A good frame updates
//   pos/err/warn with a one-cycle valid strobe. A bad frame raises a one-cycle
//   crc_err strobe and leaves the outputs unchanged.
//
// Parameters
//   POS_W     position bits per frame, MSB first (1..40)
//   AUTO_REQ  1: start a new frame as soon as the line is idle; 0: only on req
//   TOUT_CYC  minimum MA-idle cycles after the CRC before the next frame (>=2)
//   WDOG_CYC  watchdog limit in cycles spent in ACK/START
//
// Compile-time option
//   BISSC_WDOG_EN  when defined, a watchdog aborts a frame stuck in ACK/START
//                  and pulses timeout. Otherwise timeout is tied low and
//                  ACK/START wait indefinitely.
//
// Ports
//   enc_clk   in   clock (MA rate), SLO sampled on posedge
//   rst_n     in   asynchronous active-low reset
//   req       in   frame request, only looked at in IDLE
//   enc_data  in   SLO from encoder (already synchronised)
//   oclk      out  MA = enc_clk gated by the internal clock enable
//   pos       out  last CRC-good position
//   err       out  encoder error flag (inverted nError of last good frame)
//   warn      out  encoder warning flag (inverted nWarn of last good frame)
//   valid     out  1-cycle pulse: pos/err/warn just updated
//   crc_err   out  1-cycle pulse: CRC mismatch, outputs held
//   timeout   out  1-cycle pulse: watchdog abort
//   busy      out  high in every state except IDLE
// -----------------------------------------------------------------------------
module bissc_rx #(
    parameter int POS_W    = 24,
    parameter int AUTO_REQ = 0,
    parameter int TOUT_CYC = 20,
    parameter int WDOG_CYC = 256
) (
    input  logic             enc_clk,
    input  logic             rst_n,
    input  logic             req,
    input  logic             enc_data,
    output logic             oclk,
    output logic [POS_W-1:0] pos,
    output logic             err,
    output logic             warn,
    output logic             valid,
    output logic             crc_err,
    output logic             timeout,
    output logic             busy
);

    localparam int BIT_W   = $clog2(POS_W + 1);
    // One cycle counter serves both the post-frame idle time and the watchdog,
    // so it is sized for the larger of the two limits.
    localparam int CNT_MAX = (WDOG_CYC > TOUT_CYC) ? WDOG_CYC : TOUT_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(POS_W - 1);
    localparam logic [CNT_W-1:0] TOUT_LAST = CNT_W'(TOUT_CYC - 1);
`ifdef BISSC_WDOG_EN
    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WDOG_CYC - 1);
`endif

    typedef enum logic [3:0] {
        S_IDLE,
        S_ACK,
        S_START,
        S_CDS,
        S_DATA,
        S_ERR,
        S_WARN,
        S_CRC,
        S_TOUT
    } state_t;

    state_t             state_q;
    logic               cken_q;
    logic [BIT_W-1:0]   bitcnt_q;
    logic [2:0]         crcbit_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [POS_W-1:0]   shift_q;
    logic [5:0]         crc_q;
    logic [4:0]         rxcrc_q;
    logic               nerr_q;
    logic               nwarn_q;
    logic [POS_W-1:0]   pos_q;
    logic               err_q;
    logic               warn_q;
    logic               valid_q;
    logic               crc_err_q;
`ifdef BISSC_WDOG_EN
    logic               timeout_q;
`endif

    // Serial CRC6 step for the bit currently on the line.
    logic       crc_fb;
    logic [5:0] crc_d;
    logic       crc_good;

    always_comb begin
        crc_fb = crc_q[5] ^ enc_data;
        crc_d  = {crc_q[4:0], 1'b0} ^ {4'b0000, crc_fb, crc_fb};
    end

    // The sixth received CRC bit is still on the line when the compare happens,
    // so only five bits need storing.
    assign crc_good = ((~{rxcrc_q, enc_data}) == crc_q);

    always_ff @(posedge enc_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cken_q    <= 1'b0;
            bitcnt_q  <= '0;
            crcbit_q  <= '0;
            cnt_q     <= '0;
            shift_q   <= '0;
            crc_q     <= '0;
            rxcrc_q   <= '0;
            nerr_q    <= 1'b0;
            nwarn_q   <= 1'b0;
            pos_q     <= '0;
            err_q     <= 1'b0;
            warn_q    <= 1'b0;
            valid_q   <= 1'b0;
            crc_err_q <= 1'b0;
`ifdef BISSC_WDOG_EN
            timeout_q <= 1'b0;
`endif
        end else begin
            valid_q   <= 1'b0;
            crc_err_q <= 1'b0;
`ifdef BISSC_WDOG_EN
            timeout_q <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    // SLO must be idle-high before MA is started.
                    if (enc_data && (req || (AUTO_REQ != 0))) begin
                        state_q <= S_ACK;
                        cken_q  <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                S_ACK: begin
`ifdef BISSC_WDOG_EN
                    if (cnt_q == WDOG_LAST) begin
                        state_q   <= S_TOUT;
                        cken_q    <= 1'b0;
                        timeout_q <= 1'b1;
                        cnt_q     <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (!enc_data) begin
                            state_q <= S_START;
                        end
                    end
`else
                    if (!enc_data) begin
                        state_q <= S_START;
                    end
`endif
                end
                S_START: begin
`ifdef BISSC_WDOG_EN
                    if (cnt_q == WDOG_LAST) begin
                        state_q   <= S_TOUT;
                        cken_q    <= 1'b0;
                        timeout_q <= 1'b1;
                        cnt_q     <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (enc_data) begin
                            state_q <= S_CDS;
                        end
                    end
`else
                    if (enc_data) begin
                        state_q <= S_CDS;
                    end
`endif
                end
                S_CDS: begin
                    // Control-data bit is not used by this receiver.
                    state_q  <= S_DATA;
                    bitcnt_q <= '0;
                    crc_q    <= '0;
                    shift_q  <= '0;
                end
                S_DATA: begin
                    shift_q  <= (shift_q << 1) | POS_W'(enc_data);
                    crc_q    <= crc_d;
                    bitcnt_q <= bitcnt_q + BIT_W'(1);
                    if (bitcnt_q == BIT_LAST) begin
                        state_q <= S_ERR;
                    end
                end
                S_ERR: begin
                    nerr_q  <= enc_data;
                    crc_q   <= crc_d;
                    state_q <= S_WARN;
                end
                S_WARN: begin
                    nwarn_q  <= enc_data;
                    crc_q    <= crc_d;
                    crcbit_q <= '0;
                    state_q  <= S_CRC;
                end
                S_CRC: begin
                    rxcrc_q  <= {rxcrc_q[3:0], enc_data};
                    crcbit_q <= crcbit_q + 3'd1;
                    if (crcbit_q == 3'd5) begin
                        state_q <= S_TOUT;
                        cken_q  <= 1'b0;
                        cnt_q   <= '0;
                        if (crc_good) begin
                            pos_q   <= shift_q;
                            err_q   <= ~nerr_q;
                            warn_q  <= ~nwarn_q;
                            valid_q <= 1'b1;
                        end else begin
                            crc_err_q <= 1'b1;
                        end
                    end
                end
                S_TOUT: begin
                    // Counter saturates; leaving also needs SLO back high, so a
                    // line stuck low keeps the receiver parked here.
                    if (cnt_q != TOUT_LAST) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end else if (enc_data) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cken_q  <= 1'b0;
                end
            endcase
        end
    end

    assign oclk    = enc_clk & cken_q;
    assign pos     = pos_q;
    assign err     = err_q;
    assign warn    = warn_q;
    assign valid   = valid_q;
    assign crc_err = crc_err_q;
    assign busy    = (state_q != S_IDLE);
`ifdef BISSC_WDOG_EN
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_bissc_rx.sv
`timescale 1ns/1ps
module tb_bissc_rx;

    localparam int POS_W    = 24;
    localparam int TOUT_CYC = 20;
    localparam int WDOG_CYC = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic req0, req1, ed0, ed1;
    logic oclk0, err0, warn0, valid0, crc_err0, timeout0, busy0;
    logic oclk1, err1, warn1, valid1, crc_err1, timeout1, busy1;
    logic [POS_W-1:0] pos0, pos1;

    bissc_rx #(.POS_W(POS_W), .AUTO_REQ(0), .TOUT_CYC(TOUT_CYC), .WDOG_CYC(WDOG_CYC)) u_dut (
        .enc_clk(clk), .rst_n(rst_n), .req(req0), .enc_data(ed0),
        .oclk(oclk0), .pos(pos0), .err(err0), .warn(warn0), .valid(valid0),
        .crc_err(crc_err0), .timeout(timeout0), .busy(busy0)
    );

    bissc_rx #(.POS_W(POS_W), .AUTO_REQ(1), .TOUT_CYC(TOUT_CYC), .WDOG_CYC(WDOG_CYC)) u_auto (
        .enc_clk(clk), .rst_n(rst_n), .req(req1), .enc_data(ed1),
        .oclk(oclk1), .pos(pos1), .err(err1), .warn(warn1), .valid(valid1),
        .crc_err(crc_err1), .timeout(timeout1), .busy(busy1)
    );

    int total = 0;
    int bad   = 0;

    // kind: 0 = valid, 1 = crc_err, 2 = timeout
    typedef struct {
        int               kind;
        logic [POS_W-1:0] pos;
        logic             err;
        logic             warn;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    // Reference model of the last good frame per receiver.
    logic [POS_W-1:0] gpos [2];
    logic             gerr [2];
    logic             gwarn[2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, expv);
        end else begin
            $display("check %s = %0h ok", name, act);
        end
    endtask

    // CRC6 by long division of msg * x^6 by x^6+x+1.
    function automatic logic [5:0] crc6_ref(input logic [POS_W+1:0] msg);
        logic [6:0] r;
        logic       b;
        r = '0;
        for (int i = POS_W + 1 + 6; i >= 0; i--) begin
            b = (i >= 6) ? msg[i-6] : 1'b0;
            r = {r[5:0], b};
            if (r[6]) r = r ^ 7'h43;
        end
        return r[5:0];
    endfunction

    task automatic mon_one(input int sel, input logic v, input logic ce, input logic to,
                           input logic [POS_W-1:0] p, input logic e, input logic w);
        exp_t x;
        int   kind;
        int   nstb;
        if (!(v || ce || to)) return;
        total++;
        nstb = int'(v) + int'(ce) + int'(to);
        kind = v ? 0 : (ce ? 1 : 2);
        if ((sel == 0 && q0.size() == 0) || (sel == 1 && q1.size() == 0)) begin
            bad++;
            $display("FAIL strobe_dut%0d unexpected kind=%0d actual pos=%06h required none", sel, kind, p);
            return;
        end
        x = (sel == 0) ? q0.pop_front() : q1.pop_front();
        $display("txn dut%0d kind=%0d pos=%06h err=%0b warn=%0b", sel, kind, p, e, w);
        if (nstb > 1 || kind != x.kind || p !== x.pos || e !== x.err || w !== x.warn) begin
            bad++;
            $display("FAIL strobe_dut%0d actual kind=%0d/%0d pos=%06h err=%0b warn=%0b required kind=%0d pos=%06h err=%0b warn=%0b",
                     sel, kind, nstb, p, e, w, x.kind, x.pos, x.err, x.warn);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            mon_one(0, valid0, crc_err0, timeout0, pos0, err0, warn0);
            mon_one(1, valid1, crc_err1, timeout1, pos1, err1, warn1);
        end
    end

    task automatic drive(input int sel, input logic b);
        @(negedge clk);
        if (sel == 0) ed0 = b; else ed1 = b;
    endtask

    // Plays one encoder frame and then measures how long the receiver stays
    // busy, with SLO held low for 'low' cycles before returning high.
    task automatic send_frame(input int sel, input logic [POS_W-1:0] p, input logic ne,
                              input logic nw, input bit flip, input int low, input string nm);
        exp_t       x;
        logic [5:0] c;
        int         n;
        int         expn;
        logic       b;
        if (!flip) begin
            gpos[sel] = p; gerr[sel] = ~ne; gwarn[sel] = ~nw;
            x.kind = 0;
        end else begin
            x.kind = 1;
        end
        x.pos = gpos[sel]; x.err = gerr[sel]; x.warn = gwarn[sel];
        if (sel == 0) q0.push_back(x); else q1.push_back(x);

        c = ~crc6_ref({p, ne, nw});
        if (flip) c[0] = ~c[0];

        @(negedge clk);
        if (sel == 0) begin ed0 = 1'b1; req0 = 1'b1; end else ed1 = 1'b1;
        @(negedge clk);
        req0 = 1'b0;
        drive(sel, 1'b0);
        drive(sel, 1'b0);
        drive(sel, 1'b1);          // start bit
        drive(sel, 1'b0);          // CDS
        for (int i = POS_W - 1; i >= 0; i--) drive(sel, p[i]);
        drive(sel, ne);
        drive(sel, nw);
        for (int i = 5; i >= 0; i--) drive(sel, c[i]);

        n = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            b = (k < low) ? 1'b0 : 1'b1;
            if (sel == 0) ed0 = b; else ed1 = b;
            if ((sel == 0) ? busy0 : busy1) n++;
            else break;
        end
        expn = (low + 1 > TOUT_CYC) ? low + 1 : TOUT_CYC;
        check({nm, "_tout_len"}, 64'(n), 64'(expn));
    endtask

    initial begin
        int n;
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; ed0 = 1'b1; ed1 = 1'b0;
        for (int s = 0; s < 2; s++) begin gpos[s] = '0; gerr[s] = 1'b0; gwarn[s] = 1'b0; end

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_pos", pos0, 0);
        check("rst_err_warn", {err0, warn0}, 0);
        check("rst_strobes", {valid0, crc_err0, timeout0}, 0);
        check("rst_busy", busy0, 0);
        @(posedge clk); #1;
        check("rst_oclk", oclk0, 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Good frame, correct CRC
        send_frame(0, 24'hA5A5A5, 1'b1, 1'b1, 1'b0, 0, "good_a5");
        check("pos_after_good", pos0, 24'hA5A5A5);
        // Same frame, CRC LSB flipped; SLO held low 40 cycles in TOUT
        send_frame(0, 24'hA5A5A5, 1'b1, 1'b1, 1'b1, 40, "crcbad_a5");
        check("pos_held_after_crcbad", pos0, 24'hA5A5A5);
        // Error flag set
        send_frame(0, 24'h000001, 1'b0, 1'b1, 1'b0, 0, "err_frame");
        check("err_warn_after_err_frame", {err0, warn0}, 2'b10);

`ifdef BISSC_WDOG_EN
        begin
            exp_t x;
            x.kind = 2; x.pos = gpos[0]; x.err = gerr[0]; x.warn = gwarn[0];
            q0.push_back(x);
            @(negedge clk); ed0 = 1'b1; req0 = 1'b1;
            n = 0;
            for (int k = 0; k < 400; k++) begin
                @(negedge clk);
                req0 = 1'b0;
                n++;
                if (timeout0) break;
            end
            check("wdog_cycles", 64'(n), 64'(WDOG_CYC));
            @(posedge clk); #1;
            check("wdog_oclk", oclk0, 0);
            for (int k = 0; k < 100 && busy0; k++) @(negedge clk);
            check("wdog_idle", busy0, 0);
        end
`endif

        // Reset in the middle of the DATA field
        @(negedge clk); ed0 = 1'b1; req0 = 1'b1;
        @(negedge clk); req0 = 1'b0;
        drive(0, 1'b0); drive(0, 1'b0); drive(0, 1'b1); drive(0, 1'b0);
        for (int i = 0; i < 10; i++) drive(0, i[0]);
        @(posedge clk); #2;
        check("mid_oclk_running", oclk0, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_oclk", oclk0, 0);
        check("mid_rst_busy", busy0, 0);
        check("mid_rst_pos", pos0, 0);
        check("mid_rst_valid", valid0, 0);
        for (int s = 0; s < 2; s++) begin gpos[s] = '0; gerr[s] = 1'b0; gwarn[s] = 1'b0; end
        @(negedge clk); ed0 = 1'b1;
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_busy", busy0, 0);

        // Free-running receiver, three back-to-back frames with req low
        send_frame(1, 24'h000010, 1'b1, 1'b1, 1'b0, 0, "auto_10");
        send_frame(1, 24'h000020, 1'b1, 1'b1, 1'b0, 0, "auto_20");
        send_frame(1, 24'h000030, 1'b1, 1'b1, 1'b0, 0, "auto_30");
        repeat (2) @(negedge clk);
        check("auto_final_pos", pos1, 24'h000030);

        check("q0_drained", 64'(q0.size()), 0);
        check("q1_drained", 64'(q1.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
